decode_group_queue: RTL and testbench
=====================================

# decode_group_queue

Parametrised WIDTH-lane decode stage with a DEPTH-entry decoded-group queue. It sits between fetch and rename/dispatch in the out-of-order core. Each cycle it accepts one fetch group of up to WIDTH instructions. It decodes every lane into an `instruction_info_reg_t` and buffers the decoded group. Groups are presented to rename through a valid/ready handshake, and the whole queue is discarded on a pipeline flush.

## Interface
Parameters:
- WIDTH, 2, decode lanes per group (1–4)
- DEPTH, 4, decoded-group queue entries (power of two, ≥2)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- flush  in  1  mispredict/exception flush; empties the queue
- in_valid  in  1  fetch group present
- in_ready  out  1  group accepted when in_valid && in_ready
- in_inst  in  32*WIDTH  lane i instruction at [32i+31:32i]
- in_pc  in  32  PC of lane 0; lane i PC = in_pc + 4i
- in_mask  in  WIDTH  per-lane valid
- out_valid  out  1  head group present
- out_ready  in  1  rename consumes head when out_valid && out_ready
- out_info  out  WIDTH × instruction_info_reg_t  decoded lanes; .valid = stored lane mask
- out_pc  out  32  head group lane-0 PC
- out_illegal  out  WIDTH  per-lane illegal flag (see Configuration)
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Per-lane combinational decode; each lane's fields are taken from its own instruction word.
- Extracted fields: funct3, funct7, opcode, rs1_s, rs2_s, rd_s, and the i/s/b/u/j immediates, all sign-extended per RV32I.
- op_b_reg:
  - alu_en=1, cmp_en=0, is_branch=0, is_jump=0.
  - slt/sltu: alu_en=0, cmp_en=1, cmp_operation=blt/bltu.
  - add: alu_sub if funct7[5], else alu_add.
  - sr: alu_sra if funct7[5], else alu_srl.
  - Other funct3 values: alu_operation=funct3.
- op_b_imm: same as op_b_reg, except add is always alu_add.
- op_b_br: cmp_en=1, is_branch=1, cmp_operation=funct3, alu_en=0.
- op_b_jal / op_b_jalr: is_jump=1, alu_en=1, alu_add.
- op_b_lui, op_b_auipc, op_b_load, op_b_store: alu_en=1, alu_add.
- Any other opcode: all enables 0, is_branch=0, is_jump=0 (illegal).
- Lanes with in_mask[i]=0 are stored with .valid=0.
- Queue: circular buffer with head/tail pointers modulo DEPTH plus a count register.
  - Enqueue on in_valid && in_ready && |in_mask.
  - A handshake with in_mask==0 is accepted and dropped (no enqueue).
- Ready and valid rules:
  - in_ready = rst && !flush && (count < DEPTH). There is no same-cycle bypass when full.
  - out_valid = (count != 0) && !flush.
  - Outputs are driven from the head entry.
- Simultaneous enqueue and dequeue: both pointers advance and count is unchanged.
- Flush has priority over all events: head=tail=0 and count=0 next cycle, and the input group in that cycle is discarded.
- Reset mid-operation: queue contents and pointers are cleared immediately, independent of clk.

## Timing
- Reset values: head=0, tail=0, count=0, out_valid=0, in_ready=0 while rst low, all storage 0, out_illegal=0.
- Latency: a group accepted in cycle N appears at the head with out_valid=1 in cycle N+1 if the queue was empty.
- Throughput: 1 group/cycle sustained when out_ready is held at 1.
- Full (count==DEPTH): in_ready=0. in_ready returns in the cycle after a dequeue.
- Empty: out_valid=0 and out_info is don't-care.
- Pointer wrap: tail at DEPTH-1 advances to 0; head wraps the same way.
- count, in_ready and out_valid are all registered-state derived. The only combinational input is flush (gating in_ready and out_valid).

## Configuration
- DECODE_ILLEGAL_TRAP_EN defined:
  - An illegal opcode in a masked-in lane sets out_illegal[i]=1 in the stored entry.
  - Every higher-numbered lane in that group is stored with .valid=0.
- Not defined: out_illegal is tied to 0, and illegal lanes pass through as no-ops with all enables 0.

## Test plan
- WIDTH=2, DEPTH=4. Release reset, then enqueue {add x1,x2,x3 ; sub x4,x5,x6} at PC 0x100 with mask 2'b11.
  - Next cycle: out_valid=1, out_pc=0x100.
  - Lane 0 alu_add, lane 1 alu_sub, rd_s 1/4.
- Hold out_ready=0 and offer 5 groups.
  - count reaches 4 and in_ready=0 on the 5th.
  - Pulse out_ready for one cycle: in_ready=1 the next cycle, and the 5th group is accepted with pointers wrapping to 0.
- Queue at count=2, assert in_valid, out_ready and flush together.
  - count=0 and out_valid=0 next cycle; the input group is not stored.
- Enqueue {slti x1,x2,-1 ; beq x0,x0,-8}.
  - Lane 0: alu_en=0, cmp_en=1, cmp_operation=blt, i_imm=0xFFFFFFFF.
  - Lane 1: is_branch=1, b_imm=0xFFFFFFF8.
- mask=2'b00 handshake → count stays 0. Then assert rst low mid-stream with count=3 → count=0 and out_valid=0 without a clock edge.
- With DECODE_ILLEGAL_TRAP_EN, enqueue {0x00000000 ; addi x1,x0,1}.
  - out_illegal=2'b01, and lane 1 .valid=0.
  - Without the macro: out_illegal=0 and lane 1 is valid.

Source files
------------

// File: rtl/decode_group_queue.sv
// decode_group_queue: WIDTH-lane RV32I decode stage feeding a DEPTH-entry
// circular queue of decoded groups, handed to rename over valid/ready.
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN (illegal-opcode trap marking).
// Handshake: a transfer happens on a clock edge where valid && ready are both
// high; valid never depends on ready, and flush blocks both directions.

package decode_group_queue_pkg;
  localparam logic [6:0] OP_B_REG   = 7'b0110011;
  localparam logic [6:0] OP_B_IMM   = 7'b0010011;
  localparam logic [6:0] OP_B_BR    = 7'b1100011;
  localparam logic [6:0] OP_B_JAL   = 7'b1101111;
  localparam logic [6:0] OP_B_JALR  = 7'b1100111;
  localparam logic [6:0] OP_B_LUI   = 7'b0110111;
  localparam logic [6:0] OP_B_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_B_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_B_STORE = 7'b0100011;

  // ALU op = {funct7[5], funct3} for the shift/sub variants, else {0, funct3}.
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SRA = 4'b1101;

  // Compare ops reuse the branch funct3 encoding.
  localparam logic [2:0] CMP_BLT  = 3'b100;
  localparam logic [2:0] CMP_BLTU = 3'b110;

  typedef struct packed {
    logic        valid;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [6:0]  opcode;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [4:0]  rd_s;
    logic [31:0] i_imm;
    logic [31:0] s_imm;
    logic [31:0] b_imm;
    logic [31:0] u_imm;
    logic [31:0] j_imm;
    logic        alu_en;
    logic        cmp_en;
    logic        is_branch;
    logic        is_jump;
    logic [3:0]  alu_operation;
    logic [2:0]  cmp_operation;
  } instruction_info_reg_t;

  localparam int INFO_W = $bits(instruction_info_reg_t);

  // Decode one instruction word; .valid is left 0 for the caller to set.
  function automatic instruction_info_reg_t decode_lane(input logic [31:0] inst);
    instruction_info_reg_t d;
    d        = '0;
    d.funct3 = inst[14:12];
    d.funct7 = inst[31:25];
    d.opcode = inst[6:0];
    d.rs1_s  = inst[19:15];
    d.rs2_s  = inst[24:20];
    d.rd_s   = inst[11:7];
    d.i_imm  = {{20{inst[31]}}, inst[31:20]};
    d.s_imm  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    d.b_imm  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    d.u_imm  = {inst[31:12], 12'b0};
    d.j_imm  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    case (inst[6:0])
      OP_B_REG, OP_B_IMM: begin
        d.alu_en        = 1'b1;
        d.alu_operation = {1'b0, inst[14:12]};
        case (inst[14:12])
          3'b010: begin
            d.alu_en        = 1'b0;
            d.cmp_en        = 1'b1;
            d.cmp_operation = CMP_BLT;
          end
          3'b011: begin
            d.alu_en        = 1'b0;
            d.cmp_en        = 1'b1;
            d.cmp_operation = CMP_BLTU;
          end
          // Immediate form has no subtract; funct7 there is immediate bits.
          3'b000: d.alu_operation = (inst[6:0] == OP_B_REG && inst[30]) ? ALU_SUB : ALU_ADD;
          3'b101: d.alu_operation = inst[30] ? ALU_SRA : ALU_SRL;
          default: ;
        endcase
      end
      OP_B_BR: begin
        d.cmp_en        = 1'b1;
        d.is_branch     = 1'b1;
        d.cmp_operation = inst[14:12];
      end
      OP_B_JAL, OP_B_JALR: begin
        d.is_jump       = 1'b1;
        d.alu_en        = 1'b1;
        d.alu_operation = ALU_ADD;
      end
      OP_B_LUI, OP_B_AUIPC, OP_B_LOAD, OP_B_STORE: begin
        d.alu_en        = 1'b1;
        d.alu_operation = ALU_ADD;
      end
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic is_illegal(input logic [6:0] op);
    case (op)
      OP_B_REG, OP_B_IMM, OP_B_BR, OP_B_JAL, OP_B_JALR,
      OP_B_LUI, OP_B_AUIPC, OP_B_LOAD, OP_B_STORE: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction
endpackage

module decode_group_queue
  import decode_group_queue_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [32*WIDTH-1:0]          in_inst,
  input  logic [31:0]                  in_pc,
  input  logic [WIDTH-1:0]             in_mask,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH*INFO_W-1:0]      out_info,
  output logic [31:0]                  out_pc,
  output logic [WIDTH-1:0]             out_illegal,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;
  instruction_info_reg_t r_info [DEPTH][WIDTH];
  logic [31:0]           r_pc   [DEPTH];
  instruction_info_reg_t w_dec  [WIDTH];
  logic                  w_enq;
  logic                  w_deq;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic [WIDTH-1:0]      r_ill  [DEPTH];
  logic [WIDTH-1:0]      w_ill;
`endif

  assign in_ready  = rst && !flush && (r_count < CW'(DEPTH));
  assign out_valid = (r_count != '0) && !flush;
  // An all-masked group handshakes normally but is never stored.
  assign w_enq     = in_valid && in_ready && (|in_mask);
  assign w_deq     = out_valid && out_ready;

  // Decode each lane, then qualify it with the mask (and the trap kill chain).
  always_comb begin
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic v_kill;
    v_kill = 1'b0;
    w_ill  = '0;
`endif
    for (int i = 0; i < WIDTH; i++) begin
      w_dec[i] = decode_lane(in_inst[32*i +: 32]);
`ifdef DECODE_ILLEGAL_TRAP_EN
      // Lanes after the first illegal one are squashed.
      w_dec[i].valid = in_mask[i] && !v_kill;
      w_ill[i]       = w_dec[i].valid && is_illegal(w_dec[i].opcode);
      v_kill         = v_kill || w_ill[i];
`else
      w_dec[i].valid = in_mask[i];
`endif
    end
  end

  // Queue state: async clear on reset, flush wins over enqueue/dequeue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int d = 0; d < DEPTH; d++) begin
        r_pc[d] <= '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
        r_ill[d] <= '0;
`endif
        for (int i = 0; i < WIDTH; i++) r_info[d][i] <= '0;
      end
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        for (int i = 0; i < WIDTH; i++) r_info[r_tail][i] <= w_dec[i];
        r_pc[r_tail] <= in_pc;
`ifdef DECODE_ILLEGAL_TRAP_EN
        r_ill[r_tail] <= w_ill;
`endif
        r_tail <= r_tail + PW'(1);
      end
      if (w_deq) r_head <= r_head + PW'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_out
    assign out_info[g*INFO_W +: INFO_W] = r_info[r_head][g];
  end

  assign out_pc = r_pc[r_head];
  assign count  = r_count;

`ifdef DECODE_ILLEGAL_TRAP_EN
  assign out_illegal = r_ill[r_head];
`else
  assign out_illegal = '0;
`endif
endmodule

// File: tb/tb_decode_group_queue.sv
// Bench for decode_group_queue (WIDTH=2, DEPTH=4): table-driven groups with a
// scoreboard queue, plus hand-written full/flush/immediate/reset sequences.
module tb_decode_group_queue;
  import decode_group_queue_pkg::*;

  localparam int WIDTH = 2;
  localparam int DEPTH = 4;

  typedef logic [67:0] exp_t; // {illegal[1:0], pc[31:0], lane1[16:0], lane0[16:0]}

  typedef struct {
    logic [31:0] i0;
    logic [31:0] i1;
    logic [31:0] pc;
    logic [1:0]  m;
    exp_t        e;
  } vec_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  flush = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [32*WIDTH-1:0]   in_inst = '0;
  logic [31:0]           in_pc = '0;
  logic [WIDTH-1:0]      in_mask = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [WIDTH*INFO_W-1:0] out_info;
  logic [31:0]           out_pc;
  logic [WIDTH-1:0]      out_illegal;
  logic [2:0]            count;

  logic [67:0] exp_q[$];
  vec_t        tbl[8];
  int          n_checks = 0;
  int          n_pass = 0;

  decode_group_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_info(out_info),
    .out_pc(out_pc), .out_illegal(out_illegal), .count(count)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
  endtask

  function automatic logic [16:0] lx(input logic v, input logic a, input logic c,
                                     input logic b, input logic j, input logic [3:0] ao,
                                     input logic [2:0] co, input logic [4:0] rd);
    return {v, a, c, b, j, ao, co, rd};
  endfunction

  function automatic instruction_info_reg_t lane(input int i);
    logic [WIDTH*INFO_W-1:0] v;
    v = out_info;
    return instruction_info_reg_t'(v[i*INFO_W +: INFO_W]);
  endfunction

  // Observed head summary; fields the decoder leaves unspecified are zeroed.
  function automatic exp_t obs();
    instruction_info_reg_t l;
    logic [16:0] lw [2];
    for (int i = 0; i < 2; i++) begin
      l = lane(i);
      lw[i] = l.valid ? {1'b1, l.alu_en, l.cmp_en, l.is_branch, l.is_jump,
                         l.alu_en ? l.alu_operation : 4'h0,
                         l.cmp_en ? l.cmp_operation : 3'h0, l.rd_s} : 17'h0;
    end
    return {out_illegal, out_pc, lw[1], lw[0]};
  endfunction

  // scoreboard: compare the head group whenever rename takes it
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected: got=%0h exp=none", obs());
      end else begin
        check("sb_group", 80'(obs()), 80'(exp_q.pop_front()));
      end
    end
  end

  task automatic load(input vec_t v);
    in_valid = 1'b1;
    in_inst  = {v.i1, v.i0};
    in_pc    = v.pc;
    in_mask  = v.m;
  endtask

  // driver: offer one group and wait (bounded) for acceptance
  task automatic send(input vec_t v);
    int waitc;
    waitc = 0;
    load(v);
    @(negedge clk);
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL send_timeout: got=in_ready0 exp=in_ready1");
    end else if (v.m != 2'b00) begin
      exp_q.push_back(v.e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    vec_t lsw;
    instruction_info_reg_t l0, l1;

    tbl[0] = '{32'h003100B3, 32'h40628233, 32'h100, 2'b11,
               {2'b00, 32'h100, lx(1,1,0,0,0,ALU_SUB,3'd0,5'd4), lx(1,1,0,0,0,ALU_ADD,3'd0,5'd1)}};
    tbl[1] = '{32'hFFF12093, 32'hFE000CE3, 32'h200, 2'b11,
               {2'b00, 32'h200, lx(1,0,1,1,0,4'h0,3'd0,5'd25), lx(1,0,1,0,0,4'h0,3'd4,5'd1)}};
    tbl[2] = '{32'h003100B3, 32'h40628233, 32'h180, 2'b01,
               {2'b00, 32'h180, 17'h0, lx(1,1,0,0,0,ALU_ADD,3'd0,5'd1)}};
`ifdef DECODE_ILLEGAL_TRAP_EN
    tbl[3] = '{32'h00000000, 32'h00100093, 32'h300, 2'b11,
               {2'b01, 32'h300, 17'h0, lx(1,0,0,0,0,4'h0,3'd0,5'd0)}};
`else
    tbl[3] = '{32'h00000000, 32'h00100093, 32'h300, 2'b11,
               {2'b00, 32'h300, lx(1,1,0,0,0,ALU_ADD,3'd0,5'd1), lx(1,0,0,0,0,4'h0,3'd0,5'd0)}};
`endif
    tbl[4] = '{32'h000000EF, 32'h123452B7, 32'h400, 2'b11,
               {2'b00, 32'h400, lx(1,1,0,0,0,ALU_ADD,3'd0,5'd5), lx(1,1,0,0,1,ALU_ADD,3'd0,5'd1)}};
    tbl[5] = '{32'h40225193, 32'h009443B3, 32'h500, 2'b11,
               {2'b00, 32'h500, lx(1,1,0,0,0,4'h4,3'd0,5'd7), lx(1,1,0,0,0,ALU_SRA,3'd0,5'd3)}};
    tbl[6] = '{32'h0041B133, 32'h00209463, 32'h600, 2'b11,
               {2'b00, 32'h600, lx(1,0,1,1,0,4'h0,3'd1,5'd8), lx(1,0,1,0,0,4'h0,3'd6,5'd2)}};
    tbl[7] = '{32'h40225193, 32'h009443B3, 32'h680, 2'b10,
               {2'b00, 32'h680, lx(1,1,0,0,0,4'h4,3'd0,5'd7), 17'h0}};
    lsw    = '{32'h123452B7, 32'hFE532E23, 32'h700, 2'b11,
               {2'b00, 32'h700, lx(1,1,0,0,0,ALU_ADD,3'd0,5'd28), lx(1,1,0,0,0,ALU_ADD,3'd0,5'd5)}};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", 80'(in_ready), 80'(0));
    check("rst_out_valid", 80'(out_valid), 80'(0));
    check("rst_count", 80'(count), 80'(0));
    check("rst_illegal", 80'(out_illegal), 80'(0));
    @(posedge clk); #1;
    rst = 1'b1;

    // table-driven groups, one per cycle with rename always ready
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) send(tbl[k]);
    repeat (3) @(posedge clk); #1;
    check("drain_count", 80'(count), 80'(0));

    // fill to DEPTH, fifth group stalls until one dequeue
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      load(tbl[k]);
      exp_q.push_back(tbl[k].e);
      @(posedge clk); #1;
      check("fill_count", 80'(count), 80'(k + 1));
    end
    load(tbl[4]);
    @(negedge clk);
    check("full_in_ready", 80'(in_ready), 80'(0));
    check("full_count", 80'(count), 80'(4));
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ready_after_deq", 80'(in_ready), 80'(1));
    exp_q.push_back(tbl[4].e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("wrap_count", 80'(count), 80'(4));
    out_ready = 1'b1;
    repeat (6) @(posedge clk); #1;
    check("wrap_drain_count", 80'(count), 80'(0));
    check("wrap_drain_valid", 80'(out_valid), 80'(0));

    // flush with enqueue and dequeue requested in the same cycle
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      load(tbl[k]);
      exp_q.push_back(tbl[k].e);
      @(posedge clk); #1;
    end
    load(tbl[5]);
    out_ready = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 80'(in_ready), 80'(0));
    check("flush_out_valid", 80'(out_valid), 80'(0));
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    check("flush_count", 80'(count), 80'(0));
    check("flush_valid", 80'(out_valid), 80'(0));
    @(posedge clk); #1;
    check("flush_no_store", 80'(count), 80'(0));

    // immediates and latency
    load(tbl[1]);
    exp_q.push_back(tbl[1].e);
    @(posedge clk); #1;
    check("lat_out_valid", 80'(out_valid), 80'(1));
    check("lat_out_pc", 80'(out_pc), 80'(32'h200));
    l0 = lane(0);
    l1 = lane(1);
    check("slti_alu_en", 80'(l0.alu_en), 80'(0));
    check("slti_cmp_op", 80'(l0.cmp_operation), 80'(3'b100));
    check("slti_i_imm", 80'(l0.i_imm), 80'(32'hFFFFFFFF));
    check("beq_is_branch", 80'(l1.is_branch), 80'(1));
    check("beq_b_imm", 80'(l1.b_imm), 80'(32'hFFFFFFF8));
    load(lsw);
    exp_q.push_back(lsw.e);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    l0 = lane(0);
    l1 = lane(1);
    check("lui_u_imm", 80'(l0.u_imm), 80'(32'h12345000));
    check("sw_s_imm", 80'(l1.s_imm), 80'(32'hFFFFFFFC));
    out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    out_ready = 1'b0;

    // all-masked group is accepted but dropped
    in_valid = 1'b1;
    in_mask = 2'b00;
    in_pc = 32'h800;
    @(negedge clk);
    check("mask0_in_ready", 80'(in_ready), 80'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mask0_count", 80'(count), 80'(0));
    check("mask0_out_valid", 80'(out_valid), 80'(0));

    // asynchronous reset mid-stream
    for (int k = 0; k < 3; k++) begin
      load(tbl[(k * 2) % 8]);
      exp_q.push_back(tbl[(k * 2) % 8].e);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("pre_rst_count", 80'(count), 80'(3));
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check("async_rst_count", 80'(count), 80'(0));
    check("async_rst_valid", 80'(out_valid), 80'(0));
    check("async_rst_ready", 80'(in_ready), 80'(0));
    exp_q.delete();
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_count", 80'(count), 80'(0));

    check("sb_empty", 80'(exp_q.size()), 80'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
